// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: posts CPU writes into an in-order buffer,
// holds one pending read, and serialises both onto a simple req/ack bus.
// Buffered writes always drain before the pending read, so a read sees
// every write accepted before or together with it.
module data_mem_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_wstrb,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_rd,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;

    // Write buffer storage (word address, strobes, data)
    logic [29:0] fifo_addr  [DEPTH];
    logic [3:0]  fifo_wstrb [DEPTH];
    logic [31:0] fifo_wdata [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic        read_pending;
    logic [29:0] pending_addr;

    logic full;
    logic push;
    logic pop;
    logic rd_accept;

    // Byte offset never reaches the bus
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    // Stall is decoded from registered state only
    assign full      = (count == CNT_W'(DEPTH));
    assign cpu_stall = full | read_pending;
    assign push      = (cpu_wstrb != 4'h0) && !cpu_stall;
    assign rd_accept = cpu_rd && !cpu_stall;
    assign pop       = (state == WRITE) && mem_ack;

    // Buffer payload storage, written at the tail on push
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= cpu_addr[31:2];
            fifo_wstrb[wr_ptr] <= cpu_wstrb;
            fifo_wdata[wr_ptr] <= cpu_wdata;
        end
    end

    // Buffer pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Single pending read slot, released when the response is delivered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_pending <= 1'b0;
            pending_addr <= '0;
        end else if (rd_accept) begin
            read_pending <= 1'b1;
            pending_addr <= cpu_addr[31:2];
        end else if (state == RESP) begin
            read_pending <= 1'b0;
        end
    end

    // Bus sequencing FSM with registered bus and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {fifo_addr[rd_ptr], 2'b00};
                        mem_wstrb <= fifo_wstrb[rd_ptr];
                        mem_wdata <= fifo_wdata[rd_ptr];
                    end else if (read_pending) begin
                        state     <= READ;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= {pending_addr, 2'b00};
                        mem_wstrb <= 4'h0;
                        mem_wdata <= '0;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        cpu_rdata  <= mem_rdata;
                        cpu_rvalid <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, sets the write-buffer entry count; it SHALL be a power of two, at least 2.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cpu_addr  input  32  byte address of the CPU access.
REQ-005 cpu_wstrb  input  4  byte write enables; any nonzero value SHALL be a write request.
REQ-006 cpu_wdata  input  32  write data, lane i = bits [8i+7:8i].
REQ-007 cpu_rd  input  1  read request, sampled when cpu_wstrb is 4'h0 or together with a write.
REQ-008 cpu_stall  output  1  high when the block refuses new requests.
REQ-009 cpu_rdata  output  32  read data.
REQ-010 cpu_rvalid  output  1  one-cycle pulse marking cpu_rdata valid.
REQ-011 mem_req  output  1  memory bus request.
REQ-012 mem_we  output  1  write (1) or read (0).
REQ-013 mem_addr  output  32  word-aligned address.
REQ-014 mem_wstrb  output  4  byte enables for the bus write.
REQ-015 mem_wdata  output  32  bus write data.
REQ-016 mem_ack  input  1  completion, sampled on the rising edge while mem_req is high.
REQ-017 mem_rdata  input  32  read data, valid in the ack cycle.

Function
REQ-018 Writes SHALL be posted to an in-order FIFO of DEPTH entries {addr[31:2], wstrb, wdata}.
REQ-019 A write SHALL be pushed at a rising edge when cpu_wstrb!=0 and cpu_stall==0.
REQ-020 A read SHALL be captured into a single pending register at a rising edge when cpu_rd==1 and cpu_stall==0.
REQ-021 cpu_stall SHALL equal (count==DEPTH) OR read_pending, decoded from registered state only, with no input-to-output path.
REQ-022 A write and a read in the same cycle SHALL both be accepted; the read SHALL observe that write.
REQ-023 Requests presented while cpu_stall==1 SHALL be ignored; the CPU holds them.
REQ-024 A push while count==DEPTH SHALL never occur, even if a pop happens in the same cycle.
REQ-025 FSM states SHALL be IDLE, WRITE, READ and RESP.
REQ-026 IDLE: if count>0, go to WRITE; else if read_pending, go to READ; else stay. Draining writes first keeps memory order.
REQ-027 WRITE: mem_req=1, mem_we=1, FIFO head drives mem_addr/mem_wstrb/mem_wdata; on mem_ack, pop the head and go to IDLE.
REQ-028 READ: mem_req=1, mem_we=0, mem_addr={pending_addr[31:2],2'b00}, mem_wstrb=0; on mem_ack, latch mem_rdata into cpu_rdata and go to RESP.
REQ-029 RESP: cpu_rvalid=1 for exactly one cycle, clear read_pending, go to IDLE.
REQ-030 Bus outputs SHALL stay stable while mem_req==1 and no ack has been seen.
REQ-031 mem_req SHALL be low in IDLE and RESP.
REQ-032 Minimum latencies:
- write accepted at edge N: mem_req high after edge N+1.
- read on an empty FIFO accepted at edge N: mem_req after N+1; ack at edge N+2; cpu_rvalid high in the cycle after N+2.
REQ-033 cpu_addr[1:0] SHALL be ignored for bus addressing.
REQ-034 The FIFO read/write pointers SHALL wrap modulo DEPTH.
REQ-035 count SHALL range 0..DEPTH: +1 on push only, -1 on pop only, unchanged on push and pop together.
REQ-036 cpu_rdata SHALL hold its last value until the next read completes.

Reset
REQ-037 While rst is high, these outputs SHALL be 0 and the FIFO SHALL be empty:
- mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
- cpu_rdata, cpu_rvalid, cpu_stall
- FSM state (IDLE), read_pending, pointers, count
REQ-038 Reset during WRITE or READ SHALL drop mem_req immediately, discard buffered writes and any pending read, and raise no cpu_rvalid.

Verification
REQ-039 Single write: addr=0x104, wstrb=4'hF, wdata=0xDEADBEEF, ack after 2 cycles -> one bus write, mem_addr=0x104, wdata=0xDEADBEEF; count returns to 0.
REQ-040 Fill: 5 back-to-back writes, DEPTH=4, mem_ack held low -> cpu_stall=1 after the 4th push; the 5th is held; after one ack the 5th is accepted and bus order is 1..5.
REQ-041 Read-after-write: write 0x0000_00AA to 0x20 with simultaneous read of 0x22; memory returns the written value -> the bus write precedes the read, mem_addr=0x20 for both, cpu_rvalid pulses once with cpu_rdata=0x0000_00AA.
REQ-042 Byte strobe: write wstrb=4'b0010 -> mem_wstrb=4'b0010 and mem_we=1 for that transaction.
REQ-043 Read stall: during an outstanding read, present a write -> cpu_stall=1 and the write is not pushed until the cycle after cpu_rvalid.
REQ-044 Mid-transaction reset: assert rst with mem_req high and 3 entries buffered -> mem_req=0 immediately, count=0, and no bus activity after release until a new request.
